exc_seq: RTL and testbench
==========================

# exc_seq

Exception/interrupt entry and ERET sequencer for the 5-stage MIPS pipeline. It takes the `Req` request and `EPCOut` value from the CP0 block, plus the ERET indication from the M stage. On an exception it freezes the pipeline, waits for multi-cycle units to drain, flushes F/D/E/M and redirects fetch to the handler. On ERET it flushes, redirects to EPC and pulses CP0's `EXClr`.

## Interface
Parameters:
- HANDLER_PC, 32'h0000_4180, exception/interrupt handler entry address
- DRAIN_MAX, 8, maximum number of cycles spent in a drain state before forcing the flush (≥1)

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high reset
- req  in  1  CP0 `Req`: exception or interrupt accepted this cycle
- eret_m  in  1  ERET instruction valid in the M stage
- epc  in  32  CP0 `EPCOut`
- stall_in  in  1  multi-cycle unit (mult/div, bus wait) busy; pipeline must not be flushed
- hold  out  1  freeze all pipeline registers and the PC
- flush  out  1  one-cycle clear of F/D/E/M pipeline registers
- redirect  out  1  one-cycle PC load strobe
- redirect_pc  out  32  PC value loaded when `redirect`=1
- exclr  out  1  to CP0 `EXClr`; one-cycle pulse
- active  out  1  state != IDLE
- drain_timeout  out  1  sticky; a flush was forced while stall_in=1
- exc_cnt  out  16  exceptions taken (see Configuration)
- eret_cnt  out  16  ERETs taken (see Configuration)

## Operation
- States: IDLE, DRAIN_EXC, DRAIN_ERET, FLUSH_EXC, FLUSH_ERET. Reset value is IDLE.
- IDLE behaviour:
  - req=1: accept the exception. Next state is DRAIN_EXC if stall_in=1, otherwise FLUSH_EXC.
  - req=0, eret_m=1: accept the ERET and latch `epc` into epc_q. Next state is DRAIN_ERET if stall_in=1, otherwise FLUSH_ERET.
  - req and eret_m both high: req wins and the ERET is dropped, because it is the victim instruction.
- Drain counter:
  - Width is $clog2(DRAIN_MAX+1). It is cleared on entry to either DRAIN state.
  - In a DRAIN state, exit to the matching FLUSH state when stall_in=0 or cnt==DRAIN_MAX. Otherwise cnt increments.
  - Exiting a DRAIN state because cnt==DRAIN_MAX while stall_in=1 sets drain_timeout.
- FLUSH_EXC, one cycle: flush=1, redirect=1, redirect_pc=HANDLER_PC. Then go to IDLE.
- FLUSH_ERET, one cycle: flush=1, redirect=1, redirect_pc=epc_q, exclr=1. Then go to IDLE.
- req and eret_m are ignored in every state except IDLE. CP0 holds EXL=1 after a request, so req cannot legally recur.
- Combinational outputs:
  - hold = (state!=IDLE) | (IDLE & (req | eret_m)).
  - redirect_pc = 0 whenever redirect=0.
- Reset values: all outputs 0, epc_q=0, cnt=0, drain_timeout=0, counters=0. A reset in any state returns to IDLE on the next edge, with no flush, redirect or exclr issued.

## Timing
- Request/ERET seen in cycle N with stall_in=0: hold=1 in N and N+1. flush, redirect and exclr (ERET only) are asserted in N+1. hold=0 in N+2 unless a new request arrives.
- With stall_in=1 from cycle N until it first reads 0 in cycle N+k (1≤k≤DRAIN_MAX): DRAIN occupies N+1..N+k, and the flush happens in N+k+1.
- With stall_in stuck high: DRAIN occupies N+1..N+1+DRAIN_MAX, the flush happens in N+2+DRAIN_MAX, and drain_timeout reads 1 from that same cycle onward.
- epc is sampled only in the IDLE acceptance cycle. Later changes do not affect redirect_pc.

## Configuration
- EXC_SEQ_STATS_EN defined:
  - exc_cnt increments on every FLUSH_EXC cycle; eret_cnt increments on every FLUSH_ERET cycle.
  - Both saturate at 16'hFFFF and are visible the cycle after the flush.
- EXC_SEQ_STATS_EN undefined: no counter registers are built, and exc_cnt=eret_cnt=0 constantly.

## Test plan
- Exception, no stall: req=1 at cycle 2, stall_in=0 -> hold=1 in cycles 2-3; flush=redirect=1 and redirect_pc=32'h4180 in cycle 3; all outputs 0 in cycle 4.
- ERET: eret_m=1 and epc=32'h0000_3010 at cycle 5, epc changed to 32'h0 at cycle 6 -> cycle 6 shows flush=redirect=exclr=1 and redirect_pc=32'h3010.
- Drain release: req at cycle 0, stall_in=1 in cycles 0-3 and 0 in cycle 4 -> active=1 in cycles 1-5, flush in cycle 5, drain_timeout stays 0.
- Drain timeout (DRAIN_MAX=8): req at cycle 0, stall_in held at 1 -> flush in cycle 10; drain_timeout=1 from cycle 10 and remains 1 until reset.
- Simultaneous events: req=1 and eret_m=1 in the same IDLE cycle -> redirect_pc=HANDLER_PC, exclr=0. A req pulse during DRAIN_ERET -> ignored, the ERET still completes.
- Reset mid-drain: reset=1 in cycle 3 of DRAIN_EXC -> IDLE at cycle 4 with all outputs 0 and no flush. With EXC_SEQ_STATS_EN defined, 3 exceptions plus 2 ERETs give exc_cnt=3 and eret_cnt=2.

Source files
------------

// File: rtl/exc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : exc_seq
//  Description : Exception/interrupt entry and ERET sequencer for the 5-stage
//                MIPS pipeline. Freezes the pipeline, drains multi-cycle units
//                (bounded by DRAIN_MAX), flushes F/D/E/M and redirects fetch to
//                the handler or to the latched EPC. Optional build macro:
//                EXC_SEQ_STATS_EN enables saturating exception/ERET counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module exc_seq #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter int          DRAIN_MAX  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        eret_m,
    input  logic [31:0] epc,
    input  logic        stall_in,
    output logic        hold,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        exclr,
    output logic        active,
    output logic        drain_timeout,
    output logic [15:0] exc_cnt,
    output logic [15:0] eret_cnt
);

    localparam int CNT_W = $clog2(DRAIN_MAX + 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DRAIN_MAX);

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_DRAIN_EXC  = 3'd1;
    localparam logic [2:0] c_DRAIN_ERET = 3'd2;
    localparam logic [2:0] c_FLUSH_EXC  = 3'd3;
    localparam logic [2:0] c_FLUSH_ERET = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      epc_q, epc_d;
    logic             drain_timeout_q, drain_timeout_d;

    logic             w_idle;
    logic             w_drain_done;
    logic             w_flush_exc;
    logic             w_flush_eret;

    assign w_idle       = (state_q == c_IDLE);
    assign w_drain_done = ~stall_in | (cnt_q == c_CNT_MAX);
    assign w_flush_exc  = (state_q == c_FLUSH_EXC);
    assign w_flush_eret = (state_q == c_FLUSH_ERET);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        epc_d           = epc_q;
        drain_timeout_d = drain_timeout_q;
        case (state_q)
            c_IDLE: begin
                // req has priority: a simultaneous ERET is the faulting instruction
                if (req) begin
                    state_d = stall_in ? c_DRAIN_EXC : c_FLUSH_EXC;
                    cnt_d   = '0;
                end else if (eret_m) begin
                    state_d = stall_in ? c_DRAIN_ERET : c_FLUSH_ERET;
                    cnt_d   = '0;
                    epc_d   = epc;
                end
            end
            c_DRAIN_EXC, c_DRAIN_ERET: begin
                if (w_drain_done) begin
                    state_d = (state_q == c_DRAIN_EXC) ? c_FLUSH_EXC : c_FLUSH_ERET;
                    if (stall_in) begin
                        drain_timeout_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            c_FLUSH_EXC, c_FLUSH_ERET: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= c_IDLE;
            cnt_q           <= '0;
            epc_q           <= '0;
            drain_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            epc_q           <= epc_d;
            drain_timeout_q <= drain_timeout_d;
        end
    end

    // The acceptance term is masked during reset since nothing is accepted then
    assign hold          = ~w_idle | (~reset & (req | eret_m));
    assign active        = ~w_idle;
    assign flush         = w_flush_exc | w_flush_eret;
    assign redirect      = w_flush_exc | w_flush_eret;
    assign exclr         = w_flush_eret;
    assign redirect_pc   = w_flush_exc  ? HANDLER_PC :
                           w_flush_eret ? epc_q      : 32'h0;
    assign drain_timeout = drain_timeout_q;

`ifdef EXC_SEQ_STATS_EN
    logic [15:0] exc_cnt_q, exc_cnt_d;
    logic [15:0] eret_cnt_q, eret_cnt_d;

    always_comb begin
        exc_cnt_d  = exc_cnt_q;
        eret_cnt_d = eret_cnt_q;
        if (w_flush_exc && (exc_cnt_q != 16'hFFFF)) begin
            exc_cnt_d = exc_cnt_q + 16'd1;
        end
        if (w_flush_eret && (eret_cnt_q != 16'hFFFF)) begin
            eret_cnt_d = eret_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exc_cnt_q  <= 16'h0;
            eret_cnt_q <= 16'h0;
        end else begin
            exc_cnt_q  <= exc_cnt_d;
            eret_cnt_q <= eret_cnt_d;
        end
    end

    assign exc_cnt  = exc_cnt_q;
    assign eret_cnt = eret_cnt_q;
`else
    assign exc_cnt  = 16'h0;
    assign eret_cnt = 16'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exc_seq
//  Description : Self-checking bench for exc_seq: per-cycle behavioural model
//                plus directed scenarios with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exc_seq;

    localparam logic [31:0] c_HANDLER   = 32'h0000_4180;
    localparam int          c_DRAIN_MAX = 8;

    logic        clk;
    logic        reset;
    logic        req;
    logic        eret_m;
    logic [31:0] epc;
    logic        stall_in;
    logic        hold;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        exclr;
    logic        active;
    logic        drain_timeout;
    logic [15:0] exc_cnt;
    logic [15:0] eret_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    exc_seq #(
        .HANDLER_PC (c_HANDLER),
        .DRAIN_MAX  (c_DRAIN_MAX)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .eret_m        (eret_m),
        .epc           (epc),
        .stall_in      (stall_in),
        .hold          (hold),
        .flush         (flush),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .exclr         (exclr),
        .active        (active),
        .drain_timeout (drain_timeout),
        .exc_cnt       (exc_cnt),
        .eret_cnt      (eret_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A pending event is either waiting for the stall to clear (bounded by
    // c_DRAIN_MAX+1 stalled cycles) or being flushed this cycle.
    bit          m_valid = 0;
    bit          m_pending = 0;
    bit          m_flushing = 0;
    bit          m_is_eret = 0;
    int          m_stalled = 0;
    logic [31:0] m_epc = 0;
    bit          m_timeout = 0;
    int          m_exc = 0;
    int          m_eret = 0;

    always @(negedge clk) begin
        logic [31:0] e_pc;
        logic [15:0] e_exc, e_eret;
        if (m_valid) begin
            e_pc = m_flushing ? (m_is_eret ? m_epc : c_HANDLER) : 32'h0;
`ifdef EXC_SEQ_STATS_EN
            e_exc  = 16'(m_exc  > 65535 ? 65535 : m_exc);
            e_eret = 16'(m_eret > 65535 ? 65535 : m_eret);
`else
            e_exc  = 16'h0;
            e_eret = 16'h0;
`endif
            chk("m_hold", hold, m_pending || (!reset && (req || eret_m)));
            chk("m_active", active, m_pending);
            chk("m_flush", flush, m_flushing);
            chk("m_redirect", redirect, m_flushing);
            chk("m_redirect_pc", redirect_pc, e_pc);
            chk("m_exclr", exclr, m_flushing && m_is_eret);
            chk("m_drain_timeout", drain_timeout, m_timeout);
            chk("m_exc_cnt", exc_cnt, e_exc);
            chk("m_eret_cnt", eret_cnt, e_eret);
        end
        if (reset) begin
            m_valid = 1; m_pending = 0; m_flushing = 0; m_is_eret = 0;
            m_stalled = 0; m_epc = 0; m_timeout = 0; m_exc = 0; m_eret = 0;
        end else if (!m_pending) begin
            if (req || eret_m) begin
                m_pending  = 1;
                m_is_eret  = !req;
                if (!req) m_epc = epc;
                m_flushing = !stall_in;
                m_stalled  = 0;
            end
        end else if (m_flushing) begin
            if (m_is_eret) m_eret++; else m_exc++;
            m_pending  = 0;
            m_flushing = 0;
        end else begin
            if (!stall_in) begin
                m_flushing = 1;
            end else if (m_stalled == c_DRAIN_MAX) begin
                m_flushing = 1;
                m_timeout  = 1;
            end else begin
                m_stalled++;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input logic r, input logic e, input logic [31:0] p,
                       input logic s, input logic rs);
        @(posedge clk);
        #1;
        req = r; eret_m = e; epc = p; stall_in = s; reset = rs;
        @(negedge clk);
    endtask

    task automatic chk_out(input string name, input logic e_hold, input logic e_flush,
                           input logic e_exclr, input logic e_active, input logic [31:0] e_pc);
        chk({name, "_hold"}, hold, e_hold);
        chk({name, "_flush"}, flush, e_flush);
        chk({name, "_redirect"}, redirect, e_flush);
        chk({name, "_exclr"}, exclr, e_exclr);
        chk({name, "_active"}, active, e_active);
        chk({name, "_pc"}, redirect_pc, e_pc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = 1'b0; eret_m = 1'b0; epc = 32'h0; stall_in = 1'b0;
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk_out("reset", 0, 0, 0, 0, 32'h0);
        chk("reset_dt", drain_timeout, 0);
        chk("reset_exc_cnt", exc_cnt, 0);

        // exception without stall: req at cycle 2
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk_out("t1_c2", 1, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk_out("t1_c3", 1, 1, 0, 1, 32'h0000_4180);
        cyc(0, 0, 0, 0, 0);
        chk_out("t1_c4", 0, 0, 0, 0, 32'h0);

        // ERET, epc changes after acceptance
        cyc(0, 1, 32'h0000_3010, 0, 0);
        chk_out("t2_c5", 1, 0, 0, 0, 32'h0);
        cyc(0, 0, 32'h0, 0, 0);
        chk_out("t2_c6", 1, 1, 1, 1, 32'h0000_3010);
        cyc(0, 0, 0, 0, 0);
        chk_out("t2_c7", 0, 0, 0, 0, 32'h0);

        // drain released by stall going low at cycle 4
        cyc(1, 0, 0, 1, 0);
        chk_out("t3_c0", 1, 0, 0, 0, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk_out("t3_drain", 1, 0, 0, 1, 32'h0);
        end
        cyc(0, 0, 0, 0, 0);
        chk_out("t3_c4", 1, 0, 0, 1, 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk_out("t3_c5", 1, 1, 0, 1, 32'h0000_4180);
        chk("t3_dt", drain_timeout, 0);
        cyc(0, 0, 0, 0, 0);
        chk_out("t3_c6", 0, 0, 0, 0, 32'h0);

        // drain timeout with stall stuck high
        cyc(1, 0, 0, 1, 0);
        for (int i = 1; i <= 9; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk("t4_noflush", flush, 0);
        end
        chk("t4_c9_dt", drain_timeout, 0);
        cyc(0, 0, 0, 1, 0);
        chk_out("t4_c10", 1, 1, 0, 1, 32'h0000_4180);
        chk("t4_c10_dt", drain_timeout, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0);
            chk("t4_dt_sticky", drain_timeout, 1);
        end

        // simultaneous req and ERET: exception wins
        cyc(1, 1, 32'h0000_5555, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk_out("t5_both", 1, 1, 0, 1, 32'h0000_4180);
        cyc(0, 0, 0, 0, 0);
        // req pulse during DRAIN_ERET is ignored
        cyc(0, 1, 32'h0000_2000, 1, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk_out("t5_drain", 1, 0, 0, 1, 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk_out("t5_eret", 1, 1, 1, 1, 32'h0000_2000);
        chk("t5_dt", drain_timeout, 1);
        cyc(0, 0, 0, 0, 0);

        // reset in the third DRAIN_EXC cycle
        cyc(1, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        chk("t6_active_rst", active, 1);
        cyc(0, 0, 0, 0, 0);
        chk_out("t6_after", 0, 0, 0, 0, 32'h0);
        chk("t6_dt", drain_timeout, 0);
        cyc(0, 0, 0, 0, 0);
        chk_out("t6_noflush", 0, 0, 0, 0, 32'h0);

        // three exceptions and two ERETs
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 32'h0000_1000, 0, 0);
            cyc(0, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0);
`ifdef EXC_SEQ_STATS_EN
        chk("t7_exc_cnt", exc_cnt, 3);
        chk("t7_eret_cnt", eret_cnt, 2);
`else
        chk("t7_exc_cnt", exc_cnt, 0);
        chk("t7_eret_cnt", eret_cnt, 0);
`endif
        cyc(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
